prince_sbox_cms_compress: RTL and testbench

- Downstream stage of the PRINCE S-box CMS share functions.
- Consumes the NSH partial output shares produced per S-box output bit and applies a ring refresh with fresh randomness.
- Registers the refreshed shares as a glitch barrier, then XOR-compresses them into NOUT output shares per bit in a second register stage.
- Two-stage valid/ready pipeline; feeds the PRINCE linear layer.

---
 rtl/prince_sbox_cms_compress.sv | 138 +++++++++++++
 tb/tb_prince_sbox_cms_compress.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_sbox_cms_compress.sv
// ---------------------------------------------------------------------------
// prince_sbox_cms_compress
//
// Purpose:
//   Takes the partial output shares from the PRINCE S-box CMS share functions
//   and applies a ring refresh with fresh randomness. The refreshed shares are
//   registered as a glitch barrier. A second register stage then XOR-folds
//   them down to NOUT output shares per S-box output bit. The two stages form
//   a valid/ready pipeline that feeds the PRINCE linear layer.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   partial shares on in_sh are valid
//   in_ready   out  stage 1 can accept this cycle
//   in_sh      in   NB*NSH partial shares, bit b / share i at b*NSH+i
//   rnd_valid  in   refresh randomness on rnd is valid
//   rnd        in   NB*NSH refresh randomness, index b*NSH+i
//   out_valid  out  out_sh holds a compressed result
//   out_ready  in   consumer takes out_sh this cycle
//   out_sh     out  NB*NOUT compressed shares, bit b / share j at b*NOUT+j
// ---------------------------------------------------------------------------
module prince_sbox_cms_compress #(
    parameter int NB   = 4,
    parameter int NSH  = 8,
    parameter int NOUT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NB*NSH-1:0]   in_sh,
    input  logic                rnd_valid,
    input  logic [NB*NSH-1:0]   rnd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NB*NOUT-1:0]  out_sh
);

    // Number of refreshed shares folded into each output share.
    localparam int K = NSH / NOUT;

    logic                s1_valid;
    logic                s2_valid;
    logic [NB*NSH-1:0]   s1_sh;
    logic [NB*NOUT-1:0]  s2_sh;
    logic [NB*NSH-1:0]   refreshed;
    logic [NB*NOUT-1:0]  compressed;
    logic                fold;
    logic                acc;
    logic                s2_free;
    logic                move;

    // Handshake. Randomness is only consumed together with the shares, so a
    // missing rnd_valid simply stalls the producer. in_ready looks through to
    // out_ready so a full pipeline keeps streaming without a bubble.
    assign s2_free  = !s2_valid || out_ready;
    assign move     = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign acc      = in_valid && rnd_valid && in_ready;

    // Ring refresh: every random bit enters two neighbouring shares of the same
    // output bit, so the masks cancel in the XOR over all shares of that bit.
    always_comb begin
        refreshed = '0;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NSH; i++) begin
                refreshed[b*NSH + i] = in_sh[b*NSH + i]
                                     ^ rnd[b*NSH + i]
                                     ^ rnd[b*NSH + ((i + NSH - 1) % NSH)];
            end
        end
    end

    // Compression reads only the registered stage-1 shares. Combinational
    // glitches from the share functions therefore cannot reach the fold.
    always_comb begin
        compressed = '0;
        fold       = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < NOUT; j++) begin
                fold = 1'b0;
                for (int k = 0; k < K; k++) begin
                    fold = fold ^ s1_sh[b*NSH + j*K + k];
                end
                compressed[b*NOUT + j] = fold;
            end
        end
    end

    // Stage 1 valid: a new acceptance always wins. Otherwise the valid drops
    // once its item moves into stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (acc) begin
            s1_valid <= 1'b1;
        end else if (move) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 data loads only on acceptance. Held shares stay frozen while they
    // wait, and undriven inputs never enter the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sh <= '0;
        end else if (acc) begin
            s1_sh <= refreshed;
        end
    end

    // Stage 2 valid: a reload keeps it set. A consumed item with no
    // replacement clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (move) begin
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Stage 2 data loads only when stage 1 hands over an item. This keeps
    // out_sh stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sh <= '0;
        end else if (move) begin
            s2_sh <= compressed;
        end
    end

    assign out_valid = s2_valid;
    assign out_sh    = s2_sh;

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// ---------------------------------------------------------------------------
// tb_prince_sbox_cms_compress
//
// Purpose:
//   Self-checking bench for prince_sbox_cms_compress with NB=4, NSH=8 and
//   NOUT=2. A reference model works per output bit with byte-wide parity
//   arithmetic. It predicts every compressed result. A monitor then checks
//   ordering, hold stability and the XOR invariant against that model.
//   Directed phases cover latency, refresh cancellation, rnd stall,
//   backpressure, streaming and async reset.
// ---------------------------------------------------------------------------
module tb_prince_sbox_cms_compress;

    localparam int NB   = 4;
    localparam int NSH  = 8;
    localparam int NOUT = 2;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [NB*NSH-1:0]   in_sh;
    logic                rnd_valid;
    logic [NB*NSH-1:0]   rnd;
    logic                out_valid;
    logic                out_ready;
    logic [NB*NOUT-1:0]  out_sh;

    int                  checks;
    int                  errors;
    int                  out_count;
    int                  cycle_count;
    bit                  b2b_mode;
    bit                  hold_prev;
    logic [NB*NOUT-1:0]  held_sh;
    logic [NB*NOUT-1:0]  exp_q[$];
    logic [NB-1:0]       par_q[$];

    prince_sbox_cms_compress #(
        .NB   (NB),
        .NSH  (NSH),
        .NOUT (NOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh     (in_sh),
        .rnd_valid (rnd_valid),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh    (out_sh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Reference model. For each bit, the refresh mask is r plus r rotated left
    // by one share. Each output share is the parity of its group of four shares.
    function automatic logic [NB*NOUT-1:0] model_out(input logic [31:0] x, input logic [31:0] r);
        logic [NB*NOUT-1:0] res;
        logic [7:0] xb, rb, rrot, masked;
        res = '0;
        for (int b = 0; b < NB; b++) begin
            xb     = 8'((x >> (8*b)) & 32'hFF);
            rb     = 8'((r >> (8*b)) & 32'hFF);
            rrot   = {rb[6:0], rb[7]};
            masked = xb ^ rb ^ rrot;
            res[2*b]     = ^(masked & 8'h0F);
            res[2*b + 1] = ^(masked & 8'hF0);
        end
        return res;
    endfunction

    // Unmasked value of each S-box output bit, taken from the raw input shares.
    function automatic logic [NB-1:0] parity_of(input logic [31:0] x);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^x[8*b +: 8];
        return p;
    endfunction

    // Recombines the two output shares of each bit.
    function automatic logic [NB-1:0] fold_out(input logic [NB*NOUT-1:0] o);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = o[2*b] ^ o[2*b + 1];
        return p;
    endfunction

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idleInputs();
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
    endtask

    // Presents one item and waits, with a bound, until the DUT accepts it.
    // On return the caller is 1 time unit after the accepting edge, and the
    // valids are still high.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] r);
        bit accepted;
        in_sh     = x;
        rnd       = r;
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        accepted  = 1'b0;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitor. It scores every output handshake against the model queue and
    // checks that a held output stays stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            par_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_data", 32'(out_sh), 32'(held_sh));
            end
            if (b2b_mode) checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    logic [NB*NOUT-1:0] e;
                    logic [NB-1:0]      p;
                    e = exp_q.pop_front();
                    p = par_q.pop_front();
                    checkOutput("out_sh", 32'(out_sh), 32'(e));
                    checkOutput("xor_invariant", 32'(fold_out(out_sh)), 32'(p));
                end
            end
            if (in_valid && rnd_valid && in_ready) begin
                exp_q.push_back(model_out(in_sh, rnd));
                par_q.push_back(parity_of(in_sh));
            end
            hold_prev = out_valid && !out_ready;
            held_sh   = out_sh;
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] x, r;
        logic [NB*NOUT-1:0] captured;
        int c0, t0;

        checks      = 0;
        errors      = 0;
        out_count   = 0;
        cycle_count = 0;
        b2b_mode    = 1'b0;
        hold_prev   = 1'b0;
        held_sh     = '0;
        rst_n       = 1'b0;
        in_sh       = '0;
        rnd         = '0;
        out_ready   = 1'b1;
        idleInputs();

        // Reset state
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sh", 32'(out_sh), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Single item, share 0 of bit 3 set
        applyStimulus(32'h0100_0000, 32'h0);
        idleInputs();
        checkOutput("single_lat1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("single_lat2_valid", 32'(out_valid), 32'd1);
        checkOutput("single_out_sh", 32'(out_sh), 32'h40);
        @(posedge clk); #1;
        checkOutput("single_drop_valid", 32'(out_valid), 32'd0);

        // Refresh cancellation
        applyStimulus(32'h0, 32'h1);
        idleInputs();
        @(posedge clk); #1;
        checkOutput("refresh_r0_out_sh", 32'(out_sh), 32'h00);
        applyStimulus(32'h0, 32'h8);
        idleInputs();
        @(posedge clk); #1;
        checkOutput("refresh_r3_out_sh", 32'(out_sh), 32'h03);
        @(posedge clk); #1;

        // Randomness stall
        x = $urandom;
        r = $urandom;
        in_sh     = x;
        rnd       = r;
        in_valid  = 1'b1;
        rnd_valid = 1'b0;
        c0 = out_count;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_no_out", 32'(out_valid), 32'd0);
        applyStimulus(x, r);
        idleInputs();
        checkOutput("stall_lat1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("stall_lat2_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_out_sh", 32'(out_sh), 32'(model_out(x, r)));
        @(posedge clk); #1;
        checkOutput("stall_no_dup", 32'(out_valid), 32'd0);
        checkOutput("stall_out_count", 32'(out_count - c0), 32'd1);

        // Backpressure with four items in flight
        out_ready = 1'b0;
        fork
            begin
                for (int n = 0; n < 4; n++) applyStimulus($urandom, $urandom);
                idleInputs();
            end
            begin
                for (int t = 0; t < 20 && !out_valid; t++) begin
                    @(posedge clk); #1;
                end
                checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
                captured = out_sh;
                repeat (5) begin
                    @(posedge clk); #1;
                    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
                    checkOutput("bp_stable_sh", 32'(out_sh), 32'(captured));
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);

        // Back-to-back streaming
        out_ready = 1'b1;
        b2b_mode  = 1'b1;
        c0 = out_count;
        t0 = cycle_count;
        for (int n = 0; n < 100; n++) applyStimulus($urandom, $urandom);
        b2b_mode = 1'b0;
        checkOutput("b2b_cycles", 32'(cycle_count - t0), 32'd100);
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b_out_count", 32'(out_count - c0), 32'd100);

        // Async reset while an item is in flight
        applyStimulus($urandom, $urandom);
        idleInputs();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_sh", 32'(out_sh), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = out_count;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_no_stale", 32'(out_count - c0), 32'd0);
        x = $urandom;
        r = $urandom;
        applyStimulus(x, r);
        idleInputs();
        @(posedge clk); #1;
        checkOutput("rst_new_valid", 32'(out_valid), 32'd1);
        checkOutput("rst_new_sh", 32'(out_sh), 32'(model_out(x, r)));
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
